// File: rtl/sram_mem_stage_if.sv
// ============================================================================
//  Module   : sram_mem_stage_if
//  Purpose  : Bundles the pipeline-side and SRAM-side signals of the memory
//             stage. Modport slave is the stage; master is its environment.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_mem_stage_if #(
    parameter int ADDR_W = 16
);
    // From the EXE stage register
    logic              WB_EN_in;
    logic              MEM_R_EN_in;
    logic              MEM_W_EN_in;
    logic [31:0]       ALU_Res_in;
    logic [31:0]       Val_Rm_in;
    logic [3:0]        Dest_in;

    // Toward the MEM stage register and the hazard/freeze logic
    logic              WB_EN;
    logic              MEM_R_EN;
    logic [31:0]       ALU_Res;
    logic [3:0]        Dest;
    logic [31:0]       Mem_Data;
    logic              ready;

    // External SRAM port
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [31:0]       SRAM_WDATA;
    logic [31:0]       SRAM_RDATA;
    logic              SRAM_WE_N;

    modport slave (
        input  WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ALU_Res_in, Val_Rm_in, Dest_in,
        input  SRAM_RDATA,
        output WB_EN, MEM_R_EN, ALU_Res, Dest, Mem_Data, ready,
        output SRAM_ADDR, SRAM_WDATA, SRAM_WE_N
    );

    modport master (
        output WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ALU_Res_in, Val_Rm_in, Dest_in,
        output SRAM_RDATA,
        input  WB_EN, MEM_R_EN, ALU_Res, Dest, Mem_Data, ready,
        input  SRAM_ADDR, SRAM_WDATA, SRAM_WE_N
    );
endinterface

`default_nettype wire

// File: rtl/sram_mem_stage.sv
// ============================================================================
//  Module   : sram_mem_stage
//  Purpose  : ARM pipeline memory stage driving a fixed-latency SRAM; holds
//             ready low to freeze the pipeline while an access is in flight.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_mem_stage #(
    parameter int WAIT_CYCLES = 5,
    parameter int MEM_BASE    = 1024,
    parameter int ADDR_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    sram_mem_stage_if.slave    bus
);

    localparam int                CNT_W     = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [31:0]       BASE_ADDR = 32'(MEM_BASE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        mem_data;
    logic               req;
    logic               is_load;
    logic [31:0]        offset;
    logic               unused_offset_bits;

    assign req     = bus.MEM_R_EN_in | bus.MEM_W_EN_in;
    // A simultaneous read+write decode behaves as a store and never latches.
    assign is_load = bus.MEM_R_EN_in & ~bus.MEM_W_EN_in;

    assign bus.WB_EN    = bus.WB_EN_in;
    assign bus.MEM_R_EN = bus.MEM_R_EN_in;
    assign bus.ALU_Res  = bus.ALU_Res_in;
    assign bus.Dest     = bus.Dest_in;
    assign bus.Mem_Data = mem_data;

    // Byte offset into the SRAM window; out-of-range addresses simply wrap.
    assign offset             = bus.ALU_Res_in - BASE_ADDR;
    assign bus.SRAM_ADDR      = offset[ADDR_W+1:2];
    assign unused_offset_bits = ^{offset[31:ADDR_W+2], offset[1:0]};

    assign bus.SRAM_WDATA = bus.Val_Rm_in;
    assign bus.SRAM_WE_N  = ~((state == BUSY) & bus.MEM_W_EN_in);
    assign bus.ready      = ~req | (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mem_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= BUSY;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    // Losing the request mid-access means the pipeline flushed it.
                    if (!req) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state <= DONE;
                            if (is_load) begin
                                mem_data <= bus.SRAM_RDATA;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_mem_stage.sv
// ============================================================================
//  Module   : tb_sram_mem_stage
//  Purpose  : Self-checking bench for sram_mem_stage against a cycle-position
//             model of each instruction's stall window and SRAM contents.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_mem_stage;

    localparam int W      = 5;
    localparam int BASE   = 1024;
    localparam int ADDR_W = 16;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BOTH  = 3;

    logic clk;
    logic rst;

    sram_mem_stage_if #(.ADDR_W(ADDR_W)) bus ();

    sram_mem_stage #(
        .WAIT_CYCLES (W),
        .MEM_BASE    (BASE),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 64-word SRAM; reset restores a known image so the reference can track it
    logic [31:0] sram [64];
    logic [31:0] ref_mem [64];

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) sram[i] <= 32'hC0DE_0000 + 32'(i * 7);
        end else if (!bus.SRAM_WE_N) begin
            sram[bus.SRAM_ADDR[5:0]] <= bus.SRAM_WDATA;
        end
    end

    assign bus.SRAM_RDATA = sram[bus.SRAM_ADDR[5:0]];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_md;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic ref_init();
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'hC0DE_0000 + 32'(i * 7);
        exp_md = 32'h0;
    endtask

    task automatic drive(input int kind, input logic wb, input logic [31:0] alu,
                         input logic [31:0] val, input logic [3:0] dst);
        bus.WB_EN_in    = wb;
        bus.MEM_R_EN_in = (kind == K_LOAD) || (kind == K_BOTH);
        bus.MEM_W_EN_in = (kind == K_STORE) || (kind == K_BOTH);
        bus.ALU_Res_in  = alu;
        bus.Val_Rm_in   = val;
        bus.Dest_in     = dst;
    endtask

    // Presents one instruction for 'hold' cycles. A memory op completes after
    // W+2 cycles: ready is low for the first W+1 and high in the last one.
    task automatic run_op(input int kind, input logic wb, input logic [31:0] alu,
                          input logic [31:0] val, input logic [3:0] dst, input int hold);
        logic        is_mem;
        logic        is_store;
        logic [15:0] exp_addr;
        int          idx;
        is_mem   = (kind != K_ALU);
        is_store = (kind == K_STORE) || (kind == K_BOTH);
        exp_addr = 16'((alu - 32'(BASE)) >> 2);
        idx      = int'(exp_addr[5:0]);
        drive(kind, wb, alu, val, dst);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (kind == K_LOAD && k == W + 1) exp_md = ref_mem[idx];
            check_eq("ready",    32'(bus.ready),     32'(!is_mem || (k == W + 1)));
            check_eq("we_n",     32'(bus.SRAM_WE_N), 32'(!(is_store && k >= 1 && k <= W)));
            check_eq("addr",     32'(bus.SRAM_ADDR), 32'(exp_addr));
            check_eq("wdata",    bus.SRAM_WDATA,     val);
            check_eq("mem_data", bus.Mem_Data,       exp_md);
            check_eq("alu_res",  bus.ALU_Res,        alu);
            check_eq("pass",     32'({bus.WB_EN, bus.MEM_R_EN, bus.Dest}),
                                 32'({wb, bus.MEM_R_EN_in, dst}));
            @(posedge clk);
            #1;
        end
        // Any edge spent in a write cycle has already updated the SRAM word.
        if (is_store && hold >= 2) ref_mem[idx] = val;
    endtask

    function automatic logic [31:0] mem_addr(input int idx);
        return 32'(BASE) + 32'(idx * 4) + ($urandom & 32'h3);
    endfunction

    initial begin
        int          kind;
        int          hold;
        logic [31:0] a;

        rst = 1'b0;
        drive(K_ALU, 1'b0, 32'h0, 32'h0, 4'h0);
        ref_init();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready",    32'(bus.ready),     32'd1);
        check_eq("rst_we_n",     32'(bus.SRAM_WE_N), 32'd1);
        check_eq("rst_mem_data", bus.Mem_Data,       32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Directed cases
        run_op(K_ALU,   1'b1, 32'h0000_1234, 32'h0,         4'h3, 3);
        run_op(K_STORE, 1'b0, 32'd1032,      32'hDEADBEEF,  4'h0, W + 2);
        run_op(K_LOAD,  1'b1, 32'd1032,      32'h0,         4'h5, W + 2);
        check_eq("load_1032", exp_md, 32'hDEADBEEF);
        run_op(K_LOAD,  1'b1, 32'd1036,      32'h0,         4'h6, W + 2);
        run_op(K_STORE, 1'b0, 32'd1040,      32'h1234_5678, 4'h0, W + 2);
        run_op(K_BOTH,  1'b0, 32'd1044,      32'hA5A5_5A5A, 4'h0, W + 2);
        // Flush: store dropped after two BUSY cycles
        run_op(K_STORE, 1'b0, 32'd1048,      32'hCAFE_F00D, 4'h0, 3);
        run_op(K_ALU,   1'b1, 32'h0000_0777, 32'h0,         4'h2, 1);
        run_op(K_LOAD,  1'b1, 32'd1048,      32'h0,         4'h7, W + 2);

        // Reset in the middle of a store
        drive(K_STORE, 1'b0, 32'd1052, 32'h0BAD_0BAD, 4'h0);
        @(negedge clk);
        check_eq("rs_ready0", 32'(bus.ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("rs_we_busy", 32'(bus.SRAM_WE_N), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rs_we_busy2", 32'(bus.SRAM_WE_N), 32'd0);
        @(posedge clk);
        ref_init();
        @(negedge clk);
        check_eq("rs_we_n",     32'(bus.SRAM_WE_N), 32'd1);
        check_eq("rs_ready",    32'(bus.ready),     32'd0);
        check_eq("rs_mem_data", bus.Mem_Data,       32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        run_op(K_ALU,  1'b0, 32'h0000_0010, 32'h0, 4'h1, 1);
        run_op(K_LOAD, 1'b1, 32'd1052,      32'h0, 4'h4, W + 2);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 3));
            a    = (kind == K_ALU) ? $urandom : mem_addr(int'($urandom_range(0, 15)));
            if (kind != K_ALU && $urandom_range(0, 4) == 0) begin
                hold = int'($urandom_range(1, W));
                run_op(kind, 1'($urandom), a, $urandom, 4'($urandom), hold);
                run_op(K_ALU, 1'b1, $urandom, $urandom, 4'($urandom), 1);
            end else begin
                hold = (kind == K_ALU) ? 1 : W + 2;
                run_op(kind, 1'($urandom), a, $urandom, 4'($urandom), hold);
            end
        end

        // Read back every tracked word
        for (int i = 0; i < 16; i++) begin
            run_op(K_LOAD, 1'b1, mem_addr(i), 32'h0, 4'h1, W + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
